// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - shared LEGv8 datapath constants, fetch state encoding and opcode helper
//
// Purpose: constants and types shared by the fetch stage and the decode/control
// logic. OPC_MSB/OPC_LSB select the 11-bit opcode field that feeds the control
// unit from a fetched instruction word.
package legv8_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_INC  = 4;
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 21;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FULL = 2'd2
    } fetch_state_t;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - LEGv8 instruction fetch stage with req/ack memory port and branch redirect
//
// Purpose: holds the PC, fetches one 32-bit word at a time from instruction
// memory and presents it with its address to decode. A taken branch redirects
// the PC and flushes any held or in-flight instruction.
//
// Ports:
//   clk         in   sole clock, rising edge
//   reset       in   asynchronous, active-high
//   imem_req    out  read request, held until imem_ack
//   imem_addr   out  byte address of the requested word, stable while imem_req
//   imem_ack    in   one-cycle pulse, imem_rdata valid this cycle
//   imem_rdata  in   instruction word
//   if_valid    out  if_instr/if_pc hold a valid instruction
//   if_instr    out  fetched instruction
//   if_pc       out  address of if_instr
//   id_ready    in   decode consumes the instruction at this edge when if_valid
//   br_taken    in   redirect pulse
//   br_target   in   redirect address, valid with br_taken
module fetch_stage
    import legv8_pkg::*;
#(
    parameter int                  PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                if_valid,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [PC_WIDTH-1:0] if_pc,
    input  logic                id_ready,
    input  logic                br_taken,
    input  logic [PC_WIDTH-1:0] br_target
);

    fetch_state_t          r_state;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   r_req_addr;
    logic                  r_drop;
    logic                  r_if_valid;
    logic [INSTR_W-1:0]    r_if_instr;
    logic [PC_WIDTH-1:0]   r_if_pc;

    fetch_state_t          w_state_nxt;
    logic [PC_WIDTH-1:0]   w_pc_nxt;
    logic [PC_WIDTH-1:0]   w_req_addr_nxt;
    logic                  w_drop_nxt;
    logic                  w_if_valid_nxt;
    logic [INSTR_W-1:0]    w_if_instr_nxt;
    logic [PC_WIDTH-1:0]   w_if_pc_nxt;
    logic [PC_WIDTH-1:0]   w_seq_pc;
    logic [PC_WIDTH-1:0]   w_redirect_pc;

    // Sequential successor wraps naturally at 2^PC_WIDTH.
    assign w_seq_pc = r_req_addr + PC_WIDTH'(PC_INC);

    // PC to resume from after a discarded response.
    assign w_redirect_pc = br_taken ? br_target : r_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_drop     <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_instr <= '0;
            r_if_pc    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_req_addr <= w_req_addr_nxt;
            r_drop     <= w_drop_nxt;
            r_if_valid <= w_if_valid_nxt;
            r_if_instr <= w_if_instr_nxt;
            r_if_pc    <= w_if_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_req_addr_nxt = r_req_addr;
        w_drop_nxt     = r_drop;
        w_if_valid_nxt = r_if_valid;
        w_if_instr_nxt = r_if_instr;
        w_if_pc_nxt    = r_if_pc;

        unique case (r_state)
            S_IDLE: begin
                // imem_ack is deliberately ignored here so a response that
                // was outstanding across a reset cannot be captured.
                w_state_nxt    = S_REQ;
                w_req_addr_nxt = r_pc;
            end

            S_REQ: begin
                if (imem_ack) begin
                    if (r_drop || br_taken) begin
                        // Stale response: throw it away and immediately
                        // request from the (possibly new) redirect PC.
                        w_drop_nxt     = 1'b0;
                        w_pc_nxt       = w_redirect_pc;
                        w_req_addr_nxt = w_redirect_pc;
                    end else begin
                        w_if_instr_nxt = imem_rdata;
                        w_if_pc_nxt    = r_req_addr;
                        w_if_valid_nxt = 1'b1;
                        w_pc_nxt       = w_seq_pc;
                        w_state_nxt    = S_FULL;
                    end
                end else if (br_taken) begin
                    // The memory must see a stable address until it acks,
                    // so only remember the redirect and mark the reply stale.
                    w_pc_nxt   = br_target;
                    w_drop_nxt = 1'b1;
                end
            end

            S_FULL: begin
                if (br_taken) begin
                    w_if_valid_nxt = 1'b0;
                    w_pc_nxt       = br_target;
                    w_req_addr_nxt = br_target;
                    w_state_nxt    = S_REQ;
                end else if (id_ready) begin
                    w_if_valid_nxt = 1'b0;
                    w_req_addr_nxt = r_pc;
                    w_state_nxt    = S_REQ;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign imem_req  = (r_state == S_REQ);
    assign imem_addr = r_req_addr;
    assign if_valid  = r_if_valid;
    assign if_instr  = r_if_instr;
    assign if_pc     = r_if_pc;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard testbench for fetch_stage
module tb_fetch_stage;

    localparam int PW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          if_valid;
    logic [31:0]   if_instr;
    logic [PW-1:0] if_pc;
    logic          id_ready;
    logic          br_taken;
    logic [PW-1:0] br_target;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 0;
    int mem_cnt = 0;

    logic [PW-1:0] exp_addr_q[$];
    logic [PW-1:0] exp_pc_q[$];
    logic [31:0]   exp_instr_q[$];

    fetch_stage #(.PC_WIDTH(PW), .RESET_PC(64'h0)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .id_ready   (id_ready),
        .br_taken   (br_taken),
        .br_target  (br_target)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [PW-1:0] a);
        return 32'h8B00_0000 | {8'h00, a[23:0]};
    endfunction

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_addr(input logic [PW-1:0] a);
        exp_addr_q.push_back(a);
    endtask

    task automatic push_fetch(input logic [PW-1:0] a);
        exp_pc_q.push_back(a);
        exp_instr_q.push_back(mem_word(a));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            step();
            if (if_valid) break;
        end
        check("wait_valid_timeout", 64'(k < budget), 64'd1);
    endtask

    // Instruction memory: acks `lat` cycles after a request starts.
    always begin
        @(posedge clk);
        #1;
        if (reset || !imem_req) begin
            imem_ack = 1'b0;
            mem_cnt  = 0;
        end else if (mem_cnt == lat) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            mem_cnt    = 0;
        end else begin
            imem_ack = 1'b0;
            mem_cnt++;
        end
    end

    // Monitor: every ack consumes one expected address; every consumed
    // instruction consumes one expected (pc, instr) pair.
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_req && imem_ack) begin
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_request", imem_addr, 64'hDEAD);
                end else begin
                    check("imem_addr_at_ack", imem_addr, exp_addr_q.pop_front());
                end
            end
            if (if_valid && id_ready && !br_taken) begin
                if (exp_pc_q.size() == 0) begin
                    check("unexpected_consume", if_pc, 64'hDEAD);
                end else begin
                    check("if_pc_consumed", if_pc, exp_pc_q.pop_front());
                    check("if_instr_consumed", 64'(if_instr), 64'(exp_instr_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        id_ready   = 1'b0;
        br_taken   = 1'b0;
        br_target  = '0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_imem_req", 64'(imem_req), 64'd0);
        check("rst_imem_addr", imem_addr, 64'h0);
        check("rst_if_valid", 64'(if_valid), 64'd0);
        check("rst_if_instr", 64'(if_instr), 64'd0);
        check("rst_if_pc", if_pc, 64'h0);

        // Zero-wait streaming with decode always ready.
        push_addr(64'h0); push_addr(64'h4); push_addr(64'h8);
        push_fetch(64'h0); push_fetch(64'h4);
        id_ready = 1'b1;
        reset    = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("stream_if_valid", 64'(if_valid), 64'((k % 2) == 0));
            if (k == 1) begin
                check("first_req", 64'(imem_req), 64'd1);
                check("first_addr", imem_addr, 64'h0);
            end
        end
        check("stream_instr0", 64'(if_instr), 64'(mem_word(64'h8)));
        id_ready = 1'b0;

        // Stall in FULL for five cycles.
        for (int k = 0; k < 5; k++) begin
            step();
            check("stall_valid", 64'(if_valid), 64'd1);
            check("stall_req", 64'(imem_req), 64'd0);
            check("stall_pc", if_pc, 64'h8);
            check("stall_instr", 64'(if_instr), 64'(mem_word(64'h8)));
        end
        push_fetch(64'h8);
        push_addr(64'hC);
        id_ready = 1'b1;
        step();
        check("after_stall_addr", imem_addr, 64'hC);
        check("after_stall_req", 64'(imem_req), 64'd1);

        // Branch in FULL with decode ready the same cycle.
        step();
        check("full_c_pc", if_pc, 64'hC);
        push_addr(64'h40);
        br_taken  = 1'b1;
        br_target = 64'h40;
        step();
        br_taken = 1'b0;
        id_ready = 1'b0;
        check("br_full_valid", 64'(if_valid), 64'd0);
        check("br_full_req", 64'(imem_req), 64'd1);
        check("br_full_addr", imem_addr, 64'h40);
        step();
        check("full_40_pc", if_pc, 64'h40);

        // Branch while a 3-cycle request is in flight.
        lat = 3;
        push_addr(64'h8);
        push_addr(64'h100);
        br_taken  = 1'b1;
        br_target = 64'h8;
        step();
        br_taken = 1'b0;
        check("req8_addr", imem_addr, 64'h8);
        step();
        br_taken  = 1'b1;
        br_target = 64'h100;
        step();
        br_taken = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("inflight_addr", imem_addr, 64'h8);
            check("inflight_valid", 64'(if_valid), 64'd0);
            step();
        end
        check("redirect_addr", imem_addr, 64'h100);
        check("redirect_req", 64'(imem_req), 64'd1);
        check("redirect_valid", 64'(if_valid), 64'd0);
        wait_valid(20);
        check("redirect_pc", if_pc, 64'h100);
        check("redirect_instr", 64'(if_instr), 64'(mem_word(64'h100)));

        // Asynchronous reset while requesting 0xC.
        br_taken  = 1'b1;
        br_target = 64'hC;
        step();
        br_taken = 1'b0;
        check("req_c_addr", imem_addr, 64'hC);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_req", 64'(imem_req), 64'd0);
        check("async_rst_addr", imem_addr, 64'h0);
        check("async_rst_valid", 64'(if_valid), 64'd0);
        check("async_rst_pc", if_pc, 64'h0);
        check("async_rst_instr", 64'(if_instr), 64'd0);
        lat = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        push_addr(64'h0);
        step();
        check("post_rst_req", 64'(imem_req), 64'd1);
        check("post_rst_addr", imem_addr, 64'h0);
        step();
        check("post_rst_pc", if_pc, 64'h0);
        check("post_rst_instr", 64'(if_instr), 64'(mem_word(64'h0)));

        // Redirect to the top word; sequential fetch wraps to 0.
        push_addr(64'hFFFF_FFFF_FFFF_FFFC);
        push_fetch(64'hFFFF_FFFF_FFFF_FFFC);
        push_addr(64'h0);
        br_taken  = 1'b1;
        br_target = 64'hFFFF_FFFF_FFFF_FFFC;
        id_ready  = 1'b1;
        step();
        br_taken = 1'b0;
        check("wrap_top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        check("wrap_top_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        check("wrap_addr", imem_addr, 64'h0);
        step();
        id_ready = 1'b0;
        check("wrap_valid", 64'(if_valid), 64'd1);

        repeat (3) step();
        check("addr_queue_empty", 64'(exp_addr_q.size()), 64'd0);
        check("fetch_queue_empty", 64'(exp_pc_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
